digit_entry_ctrl: RTL and testbench

Parametrised N-digit keypad editor driven by the five debounced navigation buttons (Left, Right, Up, Down, Center). Holds a cursor and a packed digit register, edits one digit per button event, auto-repeats Up/Down on hold, and hands the entered value to the transaction FSM (PIN/amount entry) over a valid/ready submit handshake. Sits between the button debouncers and the ATM control FSM / 7-segment display driver.

---
 rtl/digit_entry_pkg.sv | 28 ++
 rtl/digit_entry_ctrl_btn_event_gen.sv | 66 ++++++
 rtl/digit_entry_ctrl.sv | 137 +++++++++++++
 tb/tb_digit_entry_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the keypad digit editor: button one-hot codes, FSM states,
// digit width, and small helpers.
package digit_entry_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [4:0] LEFT   = 5'b00001;
  localparam logic [4:0] RIGHT  = 5'b00010;
  localparam logic [4:0] UP     = 5'b00100;
  localparam logic [4:0] DOWN   = 5'b01000;
  localparam logic [4:0] CENTER = 5'b10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    SUBMIT = 2'd2
  } state_t;

  function automatic logic is_onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_btn_event_gen.sv
// Turns debounced button levels into one-cycle events: single-button press edges plus Up/Down
// auto-repeat. Events are combinational from the current sample (0-cycle latency); no backpressure.
module btn_event_gen
  import digit_entry_pkg::*;
#(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  output logic [4:0] evt
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [4:0]       pat;
  logic [4:0]       prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_cur, cnt_d;
  logic             rep_q, rep_cur, rep_d;
  logic             chg, hold_ud, rep_hit;

  always_comb begin
    // Zero or multiple buttons collapse to "no button" before edge detection.
    pat     = is_onehot5(btn) ? btn : 5'd0;
    chg     = (pat != prev_q);
    hold_ud = (pat == UP) || (pat == DOWN);
    // The press cycle itself counts as hold cycle 0, so the first repeat lands at DELAY-1.
    cnt_cur = chg ? '0 : cnt_q;
    rep_cur = chg ? 1'b0 : rep_q;
    rep_hit = hold_ud && (cnt_cur == (rep_cur ? RATE_LAST : DELAY_LAST));

    cnt_d = '0;
    rep_d = 1'b0;
    if (hold_ud) begin
      if (rep_hit) begin
        cnt_d = '0;
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_cur + CNT_W'(1);
        rep_d = rep_cur;
      end
    end

    evt = 5'd0;
    if ((chg && (pat != 5'd0)) || rep_hit) begin
      evt = pat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 5'd0;
      cnt_q  <= '0;
      rep_q  <= 1'b0;
    end else begin
      prev_q <= pat;
      cnt_q  <= cnt_d;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// N-digit keypad editor: cursor + packed digit register edited by button events, value offered
// on a valid/ready submit port. Edits land 1 cycle after the button sample; submit holds until ready.
module digit_entry_ctrl
  import digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_MAX    = 9,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 12_500_000,
  localparam int CW          = $clog2(NUM_DIGITS),
  localparam int DW          = DIGIT_W * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [4:0]    btn,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] data_out,
  output logic [CW-1:0] cursor,
  output logic          submit_valid,
  input  logic          submit_ready,
  output logic [DW-1:0] submit_data,
  output logic          editing
);

  localparam logic [DIGIT_W-1:0] DMAX     = DIGIT_W'(DIGIT_MAX);
  localparam logic [CW-1:0]      CUR_LAST = CW'(NUM_DIGITS - 1);

  state_t              state_q, state_d;
  logic [DW-1:0]       data_q, data_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic                vld_q, vld_d;
  logic [DW-1:0]       sdat_q, sdat_d;
  logic [4:0]          evt;
  logic [DIGIT_W-1:0]  sel, sel_inc, sel_dec;

  btn_event_gen #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_btn_event_gen (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .evt(evt)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CW'(i) == cur_q) sel = data_q[i*DIGIT_W +: DIGIT_W];
    end
    sel_inc = (sel == DMAX) ? '0 : sel + DIGIT_W'(1);
    sel_dec = (sel == '0) ? DMAX : sel - DIGIT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cur_d   = cur_q;
    vld_d   = vld_q;
    sdat_d  = sdat_q;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = EDIT;
      end
      EDIT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (!load) begin
          unique case (evt)
            LEFT:    cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + CW'(1);
            RIGHT:   cur_d = (cur_q == '0) ? CUR_LAST : cur_q - CW'(1);
            UP: begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (CW'(i) == cur_q) data_d[i*DIGIT_W +: DIGIT_W] = sel_inc;
              end
            end
            DOWN: begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (CW'(i) == cur_q) data_d[i*DIGIT_W +: DIGIT_W] = sel_dec;
              end
            end
            CENTER: begin
              sdat_d  = data_q;
              vld_d   = 1'b1;
              state_d = SUBMIT;
            end
            default: ;
          endcase
        end
      end
      SUBMIT: begin
        // en is deliberately not checked until the consumer has taken the value.
        if (vld_q && submit_ready) begin
          vld_d   = 1'b0;
          data_d  = '0;
          cur_d   = '0;
          state_d = en ? EDIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load overrides any same-cycle edit, but is locked out while a value is on offer.
    if (load && (state_q != SUBMIT)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        data_d[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_data[i*DIGIT_W +: DIGIT_W], DMAX);
      end
      cur_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cur_q   <= '0;
      vld_q   <= 1'b0;
      sdat_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      vld_q   <= vld_d;
      sdat_q  <= sdat_d;
    end
  end

  assign data_out     = data_q;
  assign cursor       = cur_q;
  assign submit_valid = vld_q;
  assign submit_data  = sdat_q;
  assign editing      = (state_q == EDIT);

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl (4 digits, decimal, short repeat timing) with a scoreboard
// queue of expected register snapshots compared after each checked clock edge.
module tb_digit_entry_ctrl;
  import digit_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  btn;
  logic        load;
  logic [15:0] load_data;
  logic [15:0] data_out;
  logic [1:0]  cursor;
  logic        submit_valid;
  logic        submit_ready;
  logic [15:0] submit_data;
  logic        editing;

  always #5 clk = ~clk;

  digit_entry_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_MAX   (9),
    .REPEAT_DELAY(8),
    .REPEAT_RATE (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .btn         (btn),
    .load        (load),
    .load_data   (load_data),
    .data_out    (data_out),
    .cursor      (cursor),
    .submit_valid(submit_valid),
    .submit_ready(submit_ready),
    .submit_data (submit_data),
    .editing     (editing)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  c;
    logic        v;
    logic [15:0] sd;
    logic        e;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string fld, input logic [15:0] obs,
                     input logic [15:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s.%s: got %h, expected %h", tag, fld, obs, want);
    end
  endtask

  task automatic compare_pop();
    exp_t  x;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: queue empty at compare");
    end else begin
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "data_out",     data_out,            x.d);
      chk(t, "cursor",       {14'd0, cursor},     {14'd0, x.c});
      chk(t, "submit_valid", {15'd0, submit_valid}, {15'd0, x.v});
      chk(t, "submit_data",  submit_data,         x.sd);
      chk(t, "editing",      {15'd0, editing},    {15'd0, x.e});
    end
  endtask

  // Queue the expected snapshot for the inputs now applied, clock once, then score it.
  task automatic st(input string tag, input logic [15:0] d, input logic [1:0] c, input logic v,
                    input logic [15:0] sd, input logic e);
    exp_t x;
    x.d  = d;
    x.c  = c;
    x.v  = v;
    x.sd = sd;
    x.e  = e;
    exp_q.push_back(x);
    tag_q.push_back(tag);
    cyc();
    compare_pop();
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    cyc();
    btn = 5'd0;
    cyc();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; btn = 5'd0; load = 1'b0; load_data = 16'h0; submit_ready = 1'b0;
    cyc();
    st("reset", 16'h0000, 2'd0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1; en = 1'b1;
    st("idle2edit", 16'h0000, 2'd0, 1'b0, 16'h0000, 1'b1);

    for (int i = 1; i <= 3; i++) begin
      btn = UP;
      st("up_pulse", 16'(i), 2'd0, 1'b0, 16'h0000, 1'b1);
      btn = 5'd0;
      cyc();
    end

    load = 1'b1; load_data = 16'h0000;
    st("load_zero", 16'h0000, 2'd0, 1'b0, 16'h0000, 1'b1);
    load = 1'b0;

    // Hold Up: events at hold cycles 1, 8, 11, 14, 17, 20.
    btn = UP;
    repeat (6) cyc();
    st("hold7", 16'h0001, 2'd0, 1'b0, 16'h0000, 1'b1);
    st("hold8", 16'h0002, 2'd0, 1'b0, 16'h0000, 1'b1);
    repeat (11) cyc();
    st("hold20", 16'h0006, 2'd0, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0;
    st("release", 16'h0006, 2'd0, 1'b0, 16'h0000, 1'b1);

    btn = RIGHT;
    st("right_wrap", 16'h0006, 2'd3, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();
    btn = DOWN;
    st("down_wrap", 16'h9006, 2'd3, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();
    btn = LEFT;
    st("left_wrap", 16'h9006, 2'd0, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();
    btn = LEFT;
    st("left", 16'h9006, 2'd1, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();

    load = 1'b1; load_data = 16'hFA27; btn = UP;
    st("load_clamp", 16'h9927, 2'd0, 1'b0, 16'h0000, 1'b1);
    load = 1'b0; btn = 5'd0;
    st("load_noevt", 16'h9927, 2'd0, 1'b0, 16'h0000, 1'b1);

    press(LEFT);
    press(LEFT);
    btn = UP;
    st("up_wrap", 16'h9027, 2'd2, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();
    press(LEFT);
    press(LEFT);
    st("cursor_back", 16'h9027, 2'd0, 1'b0, 16'h0000, 1'b1);

    btn = 5'b00110;
    repeat (9) cyc();
    st("multi_btn", 16'h9027, 2'd0, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();

    en = 1'b0;
    st("edit2idle", 16'h9027, 2'd0, 1'b0, 16'h0000, 1'b0);
    btn = UP;
    st("idle_btn", 16'h9027, 2'd0, 1'b0, 16'h0000, 1'b0);
    en = 1'b1;
    st("held_enter", 16'h9027, 2'd0, 1'b0, 16'h0000, 1'b1);
    st("held_edit", 16'h9027, 2'd0, 1'b0, 16'h0000, 1'b1);
    btn = 5'd0; cyc();

    load = 1'b1; load_data = 16'h1234;
    st("load1234", 16'h1234, 2'd0, 1'b0, 16'h0000, 1'b1);
    load = 1'b0;
    btn = CENTER;
    st("center", 16'h1234, 2'd0, 1'b1, 16'h1234, 1'b0);
    btn = UP; load = 1'b1; load_data = 16'h5555;
    st("submit_ignore", 16'h1234, 2'd0, 1'b1, 16'h1234, 1'b0);
    btn = 5'd0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st("submit_hold", 16'h1234, 2'd0, 1'b1, 16'h1234, 1'b0);
    end
    submit_ready = 1'b1;
    st("accept", 16'h0000, 2'd0, 1'b0, 16'h1234, 1'b1);
    st("ready_no_vld", 16'h0000, 2'd0, 1'b0, 16'h1234, 1'b1);
    submit_ready = 1'b0;

    press(UP);
    btn = CENTER;
    st("center2", 16'h0001, 2'd0, 1'b1, 16'h0001, 1'b0);
    btn = 5'd0; en = 1'b0;
    st("submit_en0", 16'h0001, 2'd0, 1'b1, 16'h0001, 1'b0);
    rst = 1'b0;
    st("rst_submit", 16'h0000, 2'd0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    st("post_rst_idle", 16'h0000, 2'd0, 1'b0, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
